// File: rtl/adat_tx_pkg.sv
// Shared definitions for the ADAT transmitter: frame geometry, the sample
// record and the frame builder used by the serialiser.
package adat_tx_pkg;

    localparam int FRAME_BITS    = 256;
    localparam int SYNC_ZEROS    = 10;
    localparam int NIBBLE_GROUPS = 49;

    typedef struct packed {
        logic [7:0][23:0] ch;
        logic [3:0]       user;
    } AudioFrame;

    typedef enum logic {IDLE, RUN} tx_state_t;

    // Returns the frame with line bit i at vector position FRAME_BITS-1-i.
    // The sync zeros fall out of the zero start value: only the groups and
    // the trailing '1' are shifted in from the bottom.
    function automatic logic [FRAME_BITS-1:0] build_frame(input AudioFrame f);
        logic [195:0]            payload;
        logic [FRAME_BITS-1:0]   v;
        payload = {f.user, f.ch[0], f.ch[1], f.ch[2], f.ch[3],
                   f.ch[4], f.ch[5], f.ch[6], f.ch[7]};
        v = '0;
        for (int g = 0; g < NIBBLE_GROUPS; g++) begin
            v       = {v[FRAME_BITS-6:0], 1'b1, payload[195:192]};
            payload = {payload[191:0], 4'b0000};
        end
        v = {v[FRAME_BITS-2:0], 1'b1};
        return v;
    endfunction

endpackage

// File: rtl/adat_tx_bit_clock.sv
// Phase-accumulator bit-rate generator: one-cycle tick at SAMPLE_RATE*256
// on average, derived from the CLK_FREQ system clock.
module adat_tx_bit_clock #(
    parameter int CLK_FREQ    = 100_000_000,
    parameter int SAMPLE_RATE = 48000,
    parameter int ACC_W       = 32
) (
    input  logic i_clk,
    input  logic i_rst,
    output logic o_tick
);

    localparam logic [ACC_W-1:0] STEP  = ACC_W'(SAMPLE_RATE * 256);
    localparam logic [ACC_W-1:0] LIMIT = ACC_W'(CLK_FREQ);

    logic [ACC_W-1:0] acc;
    logic [ACC_W-1:0] sum;

    always_comb begin
        sum = acc + STEP;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            acc    <= '0;
            o_tick <= 1'b0;
        end else if (sum >= LIMIT) begin
            acc    <= sum - LIMIT;
            o_tick <= 1'b1;
        end else begin
            acc    <= sum;
            o_tick <= 1'b0;
        end
    end

endmodule

// File: rtl/adat_tx.sv
// ADAT lightpipe transmitter: sample handshake into a one-deep holding
// register, 256-bit frame serialiser with NRZI line coding and word clock.
module adat_tx
    import adat_tx_pkg::*;
#(
    parameter int CLK_FREQ    = 100_000_000,
    parameter int SAMPLE_RATE = 48000,
    parameter int ACC_W       = 32
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_enable,
    input  logic [7:0][23:0] i_channels,
    input  logic [3:0]       i_user,
    input  logic             i_valid,
    output logic             o_ready,
    output logic             o_adat,
    output logic             o_word_clk,
    output logic             o_frame_start,
    output logic             o_underrun,
    output logic             o_busy
);

    logic                  tick;
    tx_state_t             state;
    logic [7:0]            bit_cnt;
    logic [7:0]            next_cnt;
    AudioFrame             hold;
    AudioFrame             frame;
    logic [FRAME_BITS-1:0] frame_vec;
    logic                  next_bit;
    logic                  accept;
    logic                  load;

    adat_tx_bit_clock #(
        .CLK_FREQ    (CLK_FREQ),
        .SAMPLE_RATE (SAMPLE_RATE),
        .ACC_W       (ACC_W)
    ) u_bit_clock (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .o_tick (tick)
    );

    // o_ready doubles as the "holding register empty" flag.
    always_comb begin
        frame_vec = build_frame(frame);
        next_cnt  = bit_cnt + 8'd1;
        next_bit  = frame_vec[~next_cnt];
        accept    = i_valid && o_ready;
        load      = tick && i_enable &&
                    ((state == IDLE) || (bit_cnt == 8'd255));
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state         <= IDLE;
            bit_cnt       <= 8'd0;
            hold          <= '0;
            frame         <= '0;
            o_adat        <= 1'b0;
            o_ready       <= 1'b1;
            o_word_clk    <= 1'b0;
            o_frame_start <= 1'b0;
            o_underrun    <= 1'b0;
            o_busy        <= 1'b0;
        end else begin
            o_frame_start <= load;
            o_underrun    <= load && o_ready;

            if (accept) begin
                hold.ch   <= i_channels;
                hold.user <= i_user;
                o_ready   <= 1'b0;
            end

            // Bit 0 is a sync zero, so starting a frame never toggles the line.
            if (load) begin
                if (!o_ready) begin
                    frame   <= hold;
                    o_ready <= 1'b1;
                end
                state      <= RUN;
                bit_cnt    <= 8'd0;
                o_word_clk <= 1'b1;
                o_busy     <= 1'b1;
            end else if (tick && state == RUN) begin
                if (bit_cnt == 8'd255) begin
                    state   <= IDLE;
                    bit_cnt <= 8'd0;
                    o_busy  <= 1'b0;
                end else begin
                    bit_cnt <= next_cnt;
                    o_adat  <= o_adat ^ next_bit;
                    if (next_cnt == 8'd128) begin
                        o_word_clk <= 1'b0;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_adat_tx.sv
// Bench for adat_tx: decodes the NRZI line at mid-bit and compares whole
// frames against a frame model built from the ADAT layout rules.
module tb_adat_tx;
    import adat_tx_pkg::*;

    localparam longint CLK_HZ   = 100_000_000;
    localparam longint BIT_RATE = 48000 * 256;

    logic             clk = 1'b0;
    logic             rst, en, valid;
    logic [7:0][23:0] chans;
    logic [3:0]       user;
    logic             adat, ready, wclk, fstart, urun, busy;

    int         errors, checks;
    logic       have_last;
    longint     last_start, run_start;
    int         run_cnt;
    logic       cont, acc_pend;
    logic [23:0] ch0_val;

    typedef struct {
        AudioFrame    s;
        logic [0:255] exp;
    } vec_t;

    adat_tx #(.CLK_FREQ(100_000_000), .SAMPLE_RATE(48000), .ACC_W(32)) dut (
        .i_clk(clk), .i_rst(rst), .i_enable(en), .i_channels(chans),
        .i_user(user), .i_valid(valid), .o_ready(ready), .o_adat(adat),
        .o_word_clk(wclk), .o_frame_start(fstart), .o_underrun(urun),
        .o_busy(busy)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    // Frame model: bit i of the line, straight from the layout rules.
    function automatic logic [0:255] model_frame(input AudioFrame s);
        logic [0:255] f;
        logic [3:0]   nib;
        int           base;
        f = '0;
        for (int g = 0; g < NIBBLE_GROUPS; g++) begin
            if (g == 0) nib = s.user;
            else        nib = s.ch[(g-1)/6][23-4*((g-1)%6) -: 4];
            base = SYNC_ZEROS + 5*g;
            f[base] = 1'b1;
            for (int b = 0; b < 4; b++) f[base+1+b] = nib[3-b];
        end
        f[255] = 1'b1;
        return f;
    endfunction

    function automatic logic [23:0] ch0_of(input logic [0:255] b);
        logic [23:0] v;
        for (int k = 0; k < 24; k++) v[23-k] = b[SYNC_ZEROS + 5*(1 + k/4) + 1 + k%4];
        return v;
    endfunction

    function automatic int bit_off(input int i);
        return int'(longint'(i) * CLK_HZ / BIT_RATE) + 4;
    endfunction

    task automatic chk_val(input string nm, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: actual=%0d expected=%0d", nm, act, exp);
        end
    endtask

    task automatic chk_rng(input string nm, input longint act, input longint lo, input longint hi);
        checks++;
        if (act < lo || act > hi) begin
            errors++;
            $display("FAIL %s: actual=%0d expected %0d..%0d", nm, act, lo, hi);
        end
    endtask

    task automatic chk_frame(input string nm, input logic [0:255] act, input logic [0:255] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%h expected=%h", nm, act, exp);
        end
    endtask

    task automatic check_reset(input string tag);
        chk_val({tag, "_adat"},        longint'(adat),   0);
        chk_val({tag, "_ready"},       longint'(ready),  1);
        chk_val({tag, "_word_clk"},    longint'(wclk),   0);
        chk_val({tag, "_frame_start"}, longint'(fstart), 0);
        chk_val({tag, "_underrun"},    longint'(urun),   0);
        chk_val({tag, "_busy"},        longint'(busy),   0);
    endtask

    task automatic drive_cont();
        if (cont) begin
            if (acc_pend) ch0_val++;
            chans[0] = ch0_val;
            acc_pend = ready;
        end
    endtask

    // Waits for the next frame start, optionally pushes a sample right after
    // the load, and NRZI-decodes all 256 bits at mid-bit.
    task automatic run_frame(input logic do_push, input AudioFrame s, input int drop_at,
                             input int exp_ur, output logic [0:255] bits,
                             output int rdy_cnt);
        logic   last, prev, lvl;
        int     n, c, bi, wc;
        longint now;
        bits = '0; rdy_cnt = 0; wc = 0; n = 0; last = adat;
        while (1'b1) begin
            @(negedge clk);
            drive_cont();
            if (fstart) break;
            last = adat;
            n++;
            if (n > 3000) break;
        end
        if (!fstart) begin
            chk_val("frame_start_timeout", longint'(fstart), 1);
            return;
        end
        now = longint'($time);
        if (have_last) begin
            chk_rng("frame_spacing", (now - last_start) / 10, 2083, 2084);
            run_cnt++;
            if (run_cnt == 10) chk_rng("ten_frame_span", (now - run_start) / 10, 20833, 20834);
        end else begin
            run_start = now;
            run_cnt   = 0;
        end
        have_last  = 1'b1;
        last_start = now;
        if (exp_ur != 2) chk_val("underrun_flag", longint'(urun), longint'(exp_ur));
        if (do_push) begin
            chk_val("ready_at_load", longint'(ready), 1);
            valid = 1'b1; user = s.user; chans = s.ch;
        end
        prev = last; c = 0; bi = 0;
        while (bi < 256) begin
            if (c == bit_off(bi)) begin
                lvl      = adat;
                bits[bi] = lvl ^ prev;
                prev     = lvl;
                bi++;
                if (bi == drop_at) en = 1'b0;
            end
            if (wclk)  wc++;
            if (ready) rdy_cnt++;
            @(negedge clk);
            c++;
            drive_cont();
            if (do_push && c == 1) valid = 1'b0;
        end
        chk_rng("word_clk_high", longint'(wc), 1041, 1042);
    endtask

    initial begin
        vec_t         tv[4];
        AudioFrame    rs[4];
        AudioFrame    prev_s, base, s;
        logic [0:255] bits;
        logic [14:0]  pre;
        logic [23:0]  last0;
        logic         pending, lvl, stable;
        int           rc, starts, n;

        errors = 0; checks = 0; have_last = 1'b0; run_cnt = 0;
        cont = 1'b0; acc_pend = 1'b0; ch0_val = '0;
        rst = 1'b1; en = 1'b0; valid = 1'b0; chans = '0; user = '0;
        repeat (3) @(posedge clk);
        #1;
        check_reset("init");
        @(negedge clk);
        rst = 1'b0;

        tv[0].s.user = 4'hA;
        tv[0].s.ch   = {24'hABCDEF, 24'h567890, 24'hF01234, 24'h9ABCDE,
                        24'h345678, 24'hDEF012, 24'h789ABC, 24'h123456};
        tv[1].s = '0;
        tv[2].s = '1;
        tv[3].s.user = 4'h5;
        for (int k = 0; k < 8; k++) tv[3].s.ch[k] = (k % 2 == 0) ? 24'h5A5A5A : 24'hA5A5A5;
        for (int i = 0; i < 4; i++) tv[i].exp = model_frame(tv[i].s);
        for (int i = 0; i < 4; i++) begin
            rs[i].user = 4'($urandom);
            for (int k = 0; k < 8; k++) rs[i].ch[k] = 24'($urandom);
        end

        en = 1'b1;
        prev_s = '0; pending = 1'b0;
        for (int i = 0; i < 4; i++) begin
            run_frame(1'b1, tv[i].s, -1, pending ? 0 : 1, bits, rc);
            chk_frame($sformatf("table_frame%0d", i), bits,
                      (i == 0) ? model_frame(prev_s) : tv[i-1].exp);
            if (i == 1) begin
                pre = bits[0:14];
                chk_val("sync_and_user", longint'(pre), 64'h1A);
                chk_val("last_bit", longint'(bits[255]), 1);
            end
            prev_s = tv[i].s; pending = 1'b1;
        end
        for (int i = 0; i < 4; i++) begin
            run_frame(1'b1, rs[i], -1, 0, bits, rc);
            chk_frame($sformatf("random_frame%0d", i), bits, model_frame(prev_s));
            prev_s = rs[i];
        end

        run_frame(1'b0, prev_s, -1, 0, bits, rc);
        chk_frame("drain_frame", bits, model_frame(prev_s));
        run_frame(1'b0, prev_s, -1, 1, bits, rc);
        chk_frame("underrun_repeat", bits, model_frame(prev_s));

        base.user = 4'($urandom);
        for (int k = 0; k < 8; k++) base.ch[k] = 24'($urandom);
        user = base.user; chans = base.ch;
        ch0_val = '0; chans[0] = '0;
        valid = 1'b1; acc_pend = ready; cont = 1'b1;
        run_frame(1'b0, base, -1, 2, bits, rc);
        last0 = ch0_of(bits);
        for (int k = 0; k < 3; k++) begin
            run_frame(1'b0, base, -1, 0, bits, rc);
            s = base; s.ch[0] = last0 + 24'd1;
            chk_val($sformatf("stream_ch0_%0d", k), longint'(ch0_of(bits)), longint'(s.ch[0]));
            chk_frame($sformatf("stream_frame%0d", k), bits, model_frame(s));
            chk_val($sformatf("stream_ready_cycles%0d", k), longint'(rc), 1);
            last0 = ch0_of(bits);
        end
        cont = 1'b0; valid = 1'b0;

        s = base; s.ch[0] = last0 + 24'd1;
        run_frame(1'b0, s, 100, 0, bits, rc);
        chk_frame("drop_enable_frame", bits, model_frame(s));
        chk_val("drop_enable_last_bit", longint'(bits[255]), 1);
        repeat (20) @(negedge clk);
        have_last = 1'b0;
        chk_val("idle_busy", longint'(busy), 0);
        lvl = adat; stable = 1'b1; starts = 0;
        repeat (300) begin
            @(negedge clk);
            if (adat !== lvl) stable = 1'b0;
            if (fstart) starts++;
        end
        chk_val("idle_line_stable", longint'(stable), 1);
        chk_val("idle_no_frames", longint'(starts), 0);

        en = 1'b1; n = 0;
        while (!fstart && n < 3000) begin
            @(negedge clk);
            n++;
        end
        chk_val("restart_frame_start", longint'(fstart), 1);
        repeat (100) @(negedge clk);
        valid = 1'b1; chans = base.ch; user = base.user;
        @(negedge clk);
        valid = 1'b0;
        chk_val("held_before_reset", longint'(ready), 0);
        repeat (400) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check_reset("midframe");
        @(negedge clk);
        rst = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/adat_tx.md
Name: adat_tx

Overview:
ADAT lightpipe transmitter, the counterpart of the in-house receiver adat_rx_adat_rx. It accepts 8×24-bit samples plus 4 user bits through a valid/ready handshake. It serialises them into 256-bit ADAT frames, NRZI-encodes the result, and drives the optical TX line at SAMPLE_RATE×256 bit/s. It also generates the matching word clock and frame strobes for the rest of the audio path.

Parameters:
CLK_FREQ, 100_000_000, system clock frequency in Hz
SAMPLE_RATE, 48000, audio sample rate in Hz; bit rate = SAMPLE_RATE*256
ACC_W, 32, phase-accumulator width; must hold CLK_FREQ + SAMPLE_RATE*256

Ports:
i_clk  in  1  system clock; the only clock
i_rst  in  1  synchronous, active-high reset
i_enable  in  1  1 = transmit frames; 0 = finish current frame, then idle
i_channels  in  8x24  sample per channel, index 0..7
i_user  in  4  user bits U3..U0
i_valid  in  1  i_channels/i_user valid
o_ready  out  1  holding register empty; sample accepted on i_valid&&o_ready
o_adat  out  1  NRZI-encoded ADAT line
o_word_clk  out  1  high during frame bits 0..127, low during 128..255
o_frame_start  out  1  1-cycle pulse when bit 0 of a frame is driven
o_underrun  out  1  1-cycle pulse when a frame starts with no new sample
o_busy  out  1  high while in RUN

Behaviour:
- Reset values: o_adat=0, o_ready=1, o_word_clk=0, o_frame_start=0, o_underrun=0, o_busy=0. The holding register, the frame register (zeros) and the accumulator are also cleared. Reset has priority over every other event.
- Bit tick: every cycle acc += SAMPLE_RATE*256. If the result is ≥ CLK_FREQ, subtract CLK_FREQ and assert tick for 1 cycle. At the defaults this averages 8.138 clocks per bit, and a frame lasts 2083 or 2084 clocks.
- Frame layout, MSB first, 256 bits:
  - bits 0..9 = 0 (sync run)
  - then 49 groups of '1' followed by 4 data bits:
    - group 0 = U3..U0
    - groups 1..48 = ch0 D23..D20, ch0 D19..D16, …, ch7 D3..D0
  - bit 255 = 1
- NRZI: on each tick, a '1' bit toggles o_adat and a '0' bit holds it. o_adat is registered and changes in the cycle after tick.
- Holding register:
  - On i_valid&&o_ready, capture i_channels/i_user; o_ready goes 0 the next cycle.
  - At each frame load, a full holding register moves into the frame register and o_ready returns to 1 the next cycle.
  - An empty holding register means the previous frame data is re-sent and o_underrun pulses.
  - If an accept and a load occur in the same cycle, the load uses the old contents and the new sample stays held, so o_ready stays 0.
- FSM IDLE/RUN:
  - IDLE: o_adat holds its level and the bit counter is 0. When i_enable=1, go to RUN on the next tick, which loads a frame and emits bit 0.
  - RUN: the bit counter 0..255 advances on tick and wraps 255→0, loading a new frame. If i_enable=0 when the counter wraps, go to IDLE instead and do not load.
- o_frame_start and o_word_clk rise in the same cycle that bit 0 is driven. o_word_clk falls when bit 128 is driven.
- Latency: a sample accepted during frame N is transmitted in frame N+1. With no backpressure, at most 1 sample is buffered.
- Deasserting i_enable mid-frame never truncates a frame.

Decomposition:
- Add to adat_rx_adat_pkg:
  - FRAME_BITS=256
  - SYNC_ZEROS=10
  - NIBBLE_GROUPS=49
  - typedef AudioFrame (8×24 samples + 4 user bits)
- Sub-module adat_tx_bit_clock: phase-accumulator tick generator (CLK_FREQ, SAMPLE_RATE, ACC_W → o_tick).

Test Plan:
- Tick rate: defaults, i_enable=1 for 10 frames → 2560 ticks. Tick spacing is always 8 or 9 clocks, and frame spacing is 2083 or 2084 clocks.
- Frame encoding: push user=4'hA, ch0..7 = 123456, 789ABC, DEF012, 345678, 9ABCDE, F01234, 567890, ABCDEF. NRZI-decode o_adat and check:
  - exactly 10 zeros, then 1, then 1010
  - the 240 data bits match
  - bit 255 = 1
- Loopback: o_adat into adat_rx_adat_rx, with a fresh sample pushed every frame for 5 frames. Check:
  - o_locked=1
  - every o_channels/o_user equals the values sent
  - the receiver's frame_time is ≈2083
- Underrun: send one sample, then stop i_valid → o_underrun pulses once per frame and the decoded data repeats the last sample.
- Handshake: hold i_valid=1 continuously → o_ready=1 for exactly one cycle per frame, and no sample is lost or duplicated (incrementing ch0 0,1,2,…).
- Enable/reset:
  - Drop i_enable at bit 100 → the frame completes through bit 255, then o_busy=0 and o_adat holds its level.
  - Assert i_rst mid-frame → every output is at its reset value on the next cycle.
